// File: rtl/inst_fmt_pkg.sv
// inst_fmt_pkg: shared definitions for the instruction loader.
//   - fmt_e        : instruction format codes (R, I, J, reserved)
//   - ld_state_e   : loader write-FSM states
//   - inst_fields_t: decoded instruction fields as presented to the loader
//   - pack_inst()  : packs a field set into a 32-bit MIPS instruction word
package inst_fmt_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_J    = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } ld_state_e;

  // Field widths
  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int TGT_W   = 26;

  // Field bit positions inside the 32-bit word
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RA_LSB    = 21;
  localparam int RB_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
  } inst_fields_t;

  // Fields not belonging to the selected format are ignored; the reserved
  // format packs to zero (the loader never pushes it anyway).
  function automatic logic [31:0] pack_inst(input fmt_e f, input inst_fields_t x);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (f)
      FMT_R: begin
        w[OPC_MSB:OPC_LSB]        = x.opcode;
        w[RA_LSB +: REG_W]        = x.ra;
        w[RB_LSB +: REG_W]        = x.rb;
        w[RD_LSB +: REG_W]        = x.rd;
        w[SHAMT_LSB +: SHAMT_W]   = x.shamt;
        w[FUNCT_W-1:0]            = x.funct;
      end
      FMT_I: begin
        w[OPC_MSB:OPC_LSB]        = x.opcode;
        w[RA_LSB +: REG_W]        = x.ra;
        w[RB_LSB +: REG_W]        = x.rb;
        w[IMM_W-1:0]              = x.imm;
      end
      FMT_J: begin
        w[OPC_MSB:OPC_LSB]        = x.opcode;
        w[TGT_W-1:0]              = x.target;
      end
      default: begin
        w = 32'h0000_0000;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH power of 2).
//   clk, rst_n     : clock, async active-low reset (FIFO emptied)
//   push, din      : write din when not full
//   pop            : drop head when not empty
//   head           : current head entry
//   head_next      : entry behind the head (valid when count >= 2)
//   full, empty    : occupancy flags from the registered count
//   count          : number of stored entries
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Qualified push/pop and next pointer/count values
  always_comb begin
    do_push_s    = push && (count_q != FULL_CNT);
    do_pop_s     = pop && (count_q != ZERO_CNT);
    rd_ptr_nxt_s = rd_ptr_q + ONE_PTR;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;   // idle, or push+pop leaves count unchanged
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_nxt_s];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == ZERO_CNT);
  assign count     = count_q;

endmodule

// File: rtl/inst_loader.sv
// inst_loader: packs decoded instruction fields into 32-bit MIPS words,
// buffers them in a FIFO and writes them to instruction memory at
// sequential word addresses over a valid/ack interface.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : field-set handshake (in_ready == !full)
//   fmt, opcode..target: decoded fields; fmt 0=R 1=I 2=J 3=reserved
//   start              : restart load at BASE_ADDR (only when idle & empty)
//   mem_we/addr/wdata  : memory write request, held until mem_ack
//   mem_ack            : memory accepted the write
//   busy               : FIFO non-empty or write outstanding
//   err                : sticky, reserved fmt accepted
//   wr_count           : words written since reset/start (saturating)
module inst_loader
  import inst_fmt_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        ra,
  input  logic [4:0]        rb,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  ld_state_e         state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;

  inst_fields_t      fields_s;
  logic [31:0]       packed_s;
  logic              accept_s, rsvd_s, push_s, pop_s;
  logic [31:0]       fifo_head_s, fifo_head_next_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [AW:0]       fifo_count_s, cnt_next_s;

  // Field bundling and packing ahead of the FIFO
  always_comb begin
    fields_s.opcode = opcode;
    fields_s.ra     = ra;
    fields_s.rb     = rb;
    fields_s.rd     = rd;
    fields_s.shamt  = shamt;
    fields_s.funct  = funct;
    fields_s.imm    = imm;
    fields_s.target = target;
    packed_s        = pack_inst(fmt_e'(fmt), fields_s);
  end

  // Handshake: in_ready is a flop, so a same-cycle pop cannot open a slot
  always_comb begin
    accept_s = in_valid && in_ready_q;
    rsvd_s   = (fmt == FMT_RSVD);
    push_s   = accept_s && !rsvd_s && !fifo_full_s;
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .din       (packed_s),
    .head      (fifo_head_s),
    .head_next (fifo_head_next_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Write FSM next-state and output-register next values
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_count_d  = wr_count_q;
    pop_s       = 1'b0;
    if (accept_s && rsvd_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = fifo_head_s;
        end else if (start && !accept_s) begin
          mem_addr_d  = BASE_ADDR;
          wr_count_d  = 16'h0000;
          err_d       = 1'b0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          pop_s      = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(4);
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end else begin
            wr_count_d = wr_count_q;
          end
          // Chain only on words already stored; a word pushed on this same
          // edge is picked up from IDLE one cycle later.
          if (fifo_count_s > ONE_CNT) begin
            mem_wdata_d = fifo_head_next_s;
          end else begin
            state_d  = ST_IDLE;
            mem_we_d = 1'b0;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Registered status derived from the post-edge occupancy
  always_comb begin
    cnt_next_s = fifo_count_s;
    if (push_s && !pop_s) begin
      cnt_next_s = fifo_count_s + ONE_CNT;
    end else if (pop_s && !push_s) begin
      cnt_next_s = fifo_count_s - ONE_CNT;
    end else begin
      cnt_next_s = fifo_count_s;
    end
    in_ready_d = (cnt_next_s != FULL_CNT);
    busy_d     = (state_d == ST_WRITE) || (cnt_next_s != ZERO_CNT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'h0000_0000;
      wr_count_q  <= 16'h0000;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_count_q  <= wr_count_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign wr_count  = wr_count_q;

endmodule
